sys_ctrl: RTL and testbench

Command sequencer between the UART receive path and the register file / ALU datapath. It parses byte frames arriving from the synchronized UART RX and turns each into register-file write/read transactions and ALU operations. It returns read data and ALU results as bytes to the TX FIFO. It owns the ALU clock-gate enable, so the ALU clock runs only while an operation is in flight.

---
 rtl/sys_ctrl_pkg.sv | 34 +++
 rtl/sys_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sys_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared definitions for the UART command sequencer.
// Holds the FSM state encoding, the frame command bytes, the error
// byte and the register-file addresses used for ALU operands.
package sys_ctrl_pkg;

  // Sequencer states
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OP_A     = 4'd5,
    OP_B     = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_LO    = 4'd9,
    TX_HI    = 4'd10
  } state_e;

  // First byte of each frame selects the command
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Byte returned for an unknown command when error reporting is built in
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  // Register-file locations feeding the ALU operands
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

endpackage

// File: rtl/sys_ctrl.sv
// sys_ctrl: command sequencer between UART RX and the register file / ALU.
// Parses byte frames (RF write, RF read, ALU with/without operands),
// drives register-file and ALU strobes, gates the ALU clock while an
// operation is in flight and returns results byte-wise to the TX FIFO.
// Optional feature: define SYS_CTRL_ERR_EN to answer unknown command
// bytes with ERR_BYTE; otherwise unknown bytes are ignored.
// All outputs are registered; reset is asynchronous, active-low.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4,
  parameter int FUN_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   RX_P_DATA,
  input  logic               RX_D_VLD,
  input  logic [WIDTH-1:0]   RdData,
  input  logic               RdData_VLD,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               ALU_OUT_VLD,
  input  logic               FIFO_FULL,
  output logic               WrEn,
  output logic               RdEn,
  output logic [ADDR-1:0]    Address,
  output logic [WIDTH-1:0]   WrData,
  output logic               ALU_EN,
  output logic [FUN_W-1:0]   ALU_FUN,
  output logic               CLK_GATE_EN,
  output logic [WIDTH-1:0]   TX_P_DATA,
  output logic               TX_D_VLD
);

  // Command bytes resized to the byte width so comparisons stay width-exact
  localparam logic [WIDTH-1:0] CMD_WR  = WIDTH'(CMD_RF_WR);
  localparam logic [WIDTH-1:0] CMD_RD  = WIDTH'(CMD_RF_RD);
  localparam logic [WIDTH-1:0] CMD_OP  = WIDTH'(CMD_ALU_OP);
  localparam logic [WIDTH-1:0] CMD_NOP = WIDTH'(CMD_ALU_NOP);

  state_e             state_reg;
  // Captured read data or ALU result; low half is sent first
  logic [2*WIDTH-1:0] result_reg;
  // Set when only the low byte of result_reg is to be returned
  logic               single_reg;

  // Sequencer FSM with all outputs registered in the same process
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      result_reg  <= '0;
      single_reg  <= 1'b0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      // Strobes are single-cycle; the gate enable is only raised by the
      // states that own an ALU operation
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      TX_D_VLD    <= 1'b0;
      CLK_GATE_EN <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_WR) begin
              state_reg <= WR_ADDR;
            end else if (RX_P_DATA == CMD_RD) begin
              state_reg <= RD_ADDR;
            end else if (RX_P_DATA == CMD_OP) begin
              state_reg <= OP_A;
            end else if (RX_P_DATA == CMD_NOP) begin
              // Operands already sit in REG0/REG1; start the ALU clock now
              state_reg   <= FUN;
              CLK_GATE_EN <= 1'b1;
            end else begin
`ifdef SYS_CTRL_ERR_EN
              // Report the unknown command through the normal TX path
              result_reg <= {{WIDTH{1'b0}}, WIDTH'(ERR_BYTE)};
              single_reg <= 1'b1;
              state_reg  <= TX_LO;
`else
              state_reg  <= IDLE;
`endif
            end
          end
        end

        WR_ADDR: begin
          if (RX_D_VLD) begin
            Address   <= RX_P_DATA[ADDR-1:0];
            state_reg <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (RX_D_VLD) begin
            WrData    <= RX_P_DATA;
            WrEn      <= 1'b1;
            state_reg <= IDLE;
          end
        end

        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address   <= RX_P_DATA[ADDR-1:0];
            RdEn      <= 1'b1;
            state_reg <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // RX bytes are dropped here; the UART cannot deliver that fast
          if (RdData_VLD) begin
            result_reg <= {{WIDTH{1'b0}}, RdData};
            single_reg <= 1'b1;
            state_reg  <= TX_LO;
          end
        end

        OP_A: begin
          if (RX_D_VLD) begin
            Address   <= ADDR'(OPA_ADDR);
            WrData    <= RX_P_DATA;
            WrEn      <= 1'b1;
            state_reg <= OP_B;
          end
        end

        OP_B: begin
          if (RX_D_VLD) begin
            Address     <= ADDR'(OPB_ADDR);
            WrData      <= RX_P_DATA;
            WrEn        <= 1'b1;
            CLK_GATE_EN <= 1'b1;
            state_reg   <= FUN;
          end
        end

        FUN: begin
          CLK_GATE_EN <= 1'b1;
          if (RX_D_VLD) begin
            ALU_FUN   <= RX_P_DATA[FUN_W-1:0];
            ALU_EN    <= 1'b1;
            state_reg <= ALU_WAIT;
          end
        end

        ALU_WAIT: begin
          // Clock stays on through the cycle after the result strobe so the
          // ALU can retire its valid flag
          CLK_GATE_EN <= 1'b1;
          if (ALU_OUT_VLD) begin
            result_reg <= ALU_OUT;
            single_reg <= 1'b0;
            state_reg  <= TX_LO;
          end
        end

        TX_LO: begin
          if (!FIFO_FULL) begin
            TX_P_DATA <= result_reg[WIDTH-1:0];
            TX_D_VLD  <= 1'b1;
            state_reg <= single_reg ? IDLE : TX_HI;
          end
        end

        TX_HI: begin
          if (!FIFO_FULL) begin
            TX_P_DATA <= result_reg[2*WIDTH-1:WIDTH];
            TX_D_VLD  <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed self-checking bench for sys_ctrl.
// Includes a small register-file model (reset to zero by RST) and an ALU
// model that answers ALU_EN with a fixed result a few cycles later.
`timescale 1ns/1ps
module tb_sys_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RdData;
  logic        RdData_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        FIFO_FULL;
  logic        WrEn;
  logic        RdEn;
  logic [3:0]  Address;
  logic [7:0]  WrData;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;

  sys_ctrl #(.WIDTH(8), .ADDR(4), .FUN_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_VLD(RdData_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Register-file model
  logic [7:0] rf [16];
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      RdData     <= 8'h00;
      RdData_VLD <= 1'b0;
    end else begin
      if (WrEn) rf[Address] <= WrData;
      RdData_VLD <= RdEn;
      if (RdEn) RdData <= rf[Address];
    end
  end

  // ALU model: result valid three cycles after ALU_EN is seen
  logic [15:0] alu_result;
  int          alu_dly;
  assign ALU_OUT = alu_result;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_dly     <= 0;
      ALU_OUT_VLD <= 1'b0;
    end else begin
      if (ALU_EN) alu_dly <= 3;
      else if (alu_dly != 0) alu_dly <= alu_dly - 1;
      ALU_OUT_VLD <= (alu_dly == 1);
    end
  end

  // Transaction monitor, sampled on the falling edge
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [7:0] tx_q [$];
  int         rd_cnt = 0;
  int         rd_last_addr = 0;
  int         alu_cnt = 0;
  logic [3:0] last_fun = 4'h0;
  logic       gate_at_en = 1'b0;
  logic       gate_at_vld = 1'b0;
  int         both_cnt = 0;
  int         gate_bad_cnt = 0;
  logic       gate_allowed = 1'b0;

  always @(negedge CLK) begin
    if (WrEn) begin
      wr_addr_q.push_back(Address);
      wr_data_q.push_back(WrData);
      $display("[%0t] RF write addr=%0h data=%02h", $time, Address, WrData);
    end
    if (RdEn) begin
      rd_cnt       <= rd_cnt + 1;
      rd_last_addr <= int'(Address);
      $display("[%0t] RF read addr=%0h", $time, Address);
    end
    if (ALU_EN) begin
      alu_cnt    <= alu_cnt + 1;
      last_fun   <= ALU_FUN;
      gate_at_en <= CLK_GATE_EN;
      $display("[%0t] ALU start fun=%0h", $time, ALU_FUN);
    end
    if (ALU_OUT_VLD) gate_at_vld <= CLK_GATE_EN;
    if (TX_D_VLD) begin
      tx_q.push_back(TX_P_DATA);
      $display("[%0t] TX byte=%02h", $time, TX_P_DATA);
    end
    if (WrEn && RdEn) both_cnt <= both_cnt + 1;
    if (CLK_GATE_EN && !gate_allowed) gate_bad_cnt <= gate_bad_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Wait for the TX queue to reach n bytes; expired budget is a failure
  task automatic wait_tx(input int n, input string tag);
    int budget;
    budget = 60;
    while (tx_q.size() < n && budget > 0) begin
      @(posedge CLK);
      budget--;
    end
    #1;
    check(tag, (budget > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wren"},  32'(WrEn), 32'd0);
    check({tag, "_rden"},  32'(RdEn), 32'd0);
    check({tag, "_addr"},  32'(Address), 32'd0);
    check({tag, "_wrdata"}, 32'(WrData), 32'd0);
    check({tag, "_aluen"}, 32'(ALU_EN), 32'd0);
    check({tag, "_alufun"}, 32'(ALU_FUN), 32'd0);
    check({tag, "_gate"},  32'(CLK_GATE_EN), 32'd0);
    check({tag, "_txdata"}, 32'(TX_P_DATA), 32'd0);
    check({tag, "_txvld"}, 32'(TX_D_VLD), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int alu0;
    RST        = 1'b0;
    RX_P_DATA  = 8'h00;
    RX_D_VLD   = 1'b0;
    FIFO_FULL  = 1'b0;
    alu_result = 16'h0000;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    @(negedge CLK);
    RST = 1'b1;
    idle(2);

    // RF write then read back of the same address
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle(3);
    check("wr1_count", 32'(wr_addr_q.size()), 32'd1);
    check("wr1_addr",  32'(wr_addr_q[0]), 32'h5);
    check("wr1_data",  32'(wr_data_q[0]), 32'h3C);
    send_byte(8'hBB); send_byte(8'h05);
    wait_tx(1, "rd1_tx_arrived");
    idle(5);
    check("rd1_count",   32'(rd_cnt), 32'd1);
    check("rd1_addr",    32'(rd_last_addr), 32'd5);
    check("rd1_tx_size", 32'(tx_q.size()), 32'd1);
    check("rd1_tx_byte", 32'(tx_q[0]), 32'h3C);
    check("rd1_gate_off", 32'(gate_bad_cnt), 32'd0);
    tx_q.delete();

    // ALU with operands: 7 and 3, function 0, result 0x000A
    alu_result   = 16'h000A;
    gate_allowed = 1'b1;
    wr0 = wr_addr_q.size();
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03); send_byte(8'h00);
    wait_tx(2, "op_tx_arrived");
    idle(3);
    gate_allowed = 1'b0;
    check("op_wr_count", 32'(wr_addr_q.size() - wr0), 32'd2);
    check("op_wr_a_addr", 32'(wr_addr_q[wr0]), 32'h0);
    check("op_wr_a_data", 32'(wr_data_q[wr0]), 32'h07);
    check("op_wr_b_addr", 32'(wr_addr_q[wr0+1]), 32'h1);
    check("op_wr_b_data", 32'(wr_data_q[wr0+1]), 32'h03);
    check("op_alu_count", 32'(alu_cnt), 32'd1);
    check("op_alu_fun",   32'(last_fun), 32'h0);
    check("op_gate_at_en", 32'(gate_at_en), 32'd1);
    check("op_tx_size", 32'(tx_q.size()), 32'd2);
    check("op_tx_lo",   32'(tx_q[0]), 32'h0A);
    check("op_tx_hi",   32'(tx_q[1]), 32'h00);
    check("op_gate_low_after", 32'(CLK_GATE_EN), 32'd0);
    tx_q.delete();

    // ALU without operands, function 2
    alu_result   = 16'h1234;
    gate_allowed = 1'b1;
    wr0  = wr_addr_q.size();
    alu0 = alu_cnt;
    send_byte(8'hDD); send_byte(8'h02);
    wait_tx(2, "nop_tx_arrived");
    idle(3);
    gate_allowed = 1'b0;
    check("nop_no_write",  32'(wr_addr_q.size() - wr0), 32'd0);
    check("nop_alu_count", 32'(alu_cnt - alu0), 32'd1);
    check("nop_alu_fun",   32'(last_fun), 32'h2);
    check("nop_gate_at_en",  32'(gate_at_en), 32'd1);
    check("nop_gate_at_vld", 32'(gate_at_vld), 32'd1);
    check("nop_tx_size", 32'(tx_q.size()), 32'd2);
    check("nop_tx_lo",   32'(tx_q[0]), 32'h34);
    check("nop_tx_hi",   32'(tx_q[1]), 32'h12);
    check("nop_gate_outside", 32'(gate_bad_cnt), 32'd0);
    tx_q.delete();

    // FIFO_FULL held for 10 cycles while the high byte is pending
    alu_result   = 16'hBEEF;
    gate_allowed = 1'b1;
    send_byte(8'hDD); send_byte(8'h05);
    begin
      int budget;
      budget = 60;
      while (!TX_D_VLD && budget > 0) begin
        @(negedge CLK);
        budget--;
      end
      check("ff_lo_seen", (budget > 0) ? 32'd1 : 32'd0, 32'd1);
    end
    FIFO_FULL = 1'b1;
    repeat (10) @(negedge CLK);
    check("ff_hold_size", 32'(tx_q.size()), 32'd1);
    check("ff_hold_vld",  32'(TX_D_VLD), 32'd0);
    FIFO_FULL = 1'b0;
    wait_tx(2, "ff_hi_arrived");
    idle(5);
    gate_allowed = 1'b0;
    check("ff_tx_size", 32'(tx_q.size()), 32'd2);
    check("ff_tx_lo",   32'(tx_q[0]), 32'hEF);
    check("ff_tx_hi",   32'(tx_q[1]), 32'hBE);
    tx_q.delete();

    // Unknown command byte, then a normal write
    wr0  = wr_addr_q.size();
    alu0 = alu_cnt;
    send_byte(8'h55);
    idle(10);
`ifdef SYS_CTRL_ERR_EN
    check("unk_tx_size", 32'(tx_q.size()), 32'd1);
    check("unk_tx_byte", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF, 32'hEE);
`else
    check("unk_tx_size", 32'(tx_q.size()), 32'd0);
`endif
    check("unk_no_write", 32'(wr_addr_q.size() - wr0), 32'd0);
    check("unk_no_alu",   32'(alu_cnt - alu0), 32'd0);
    tx_q.delete();
    send_byte(8'hAA); send_byte(8'h09); send_byte(8'h77);
    idle(3);
    check("unk_wr_count", 32'(wr_addr_q.size() - wr0), 32'd1);
    check("unk_wr_addr",  32'(wr_addr_q[wr0]), 32'h9);
    check("unk_wr_data",  32'(wr_data_q[wr0]), 32'h77);

    // Reset in the middle of an RF write frame
    wr0 = wr_addr_q.size();
    send_byte(8'hAA); send_byte(8'h05);
    #3;
    RST = 1'b0;
    #2;
    check_outputs_zero("midrst");
    idle(2);
    @(negedge CLK);
    RST = 1'b1;
    idle(3);
    check("midrst_no_write", 32'(wr_addr_q.size() - wr0), 32'd0);
    send_byte(8'hBB); send_byte(8'h05);
    wait_tx(1, "midrst_rd_arrived");
    idle(5);
    check("midrst_no_write2", 32'(wr_addr_q.size() - wr0), 32'd0);
    check("midrst_tx_size", 32'(tx_q.size()), 32'd1);
    check("midrst_tx_byte", 32'(tx_q[0]), 32'h00);
    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
